// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte requesters,
// with per-packet locking and a start-of-transmission timeout.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_act,
  input  logic              i_tx_busy,
  output logic              o_busy,
  output logic              o_err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] win_reg, win_next;
  logic [IW-1:0] rr_reg, rr_next;
  logic [IW-1:0] lock_idx_reg, lock_idx_next;
  logic          lock_reg, lock_next;
  logic          last_reg, last_next;
  logic          err_reg, err_next;
  logic [7:0]    data_reg, data_next;
  logic [7:0]    cnt_reg, cnt_next;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      req_byte [NREQ];
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     idx_w;

  // While a packet is locked, only its owner may be arbitrated.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_byte[gi]   = i_data[8*gi +: 8];
      assign eligible[gi]   = i_req[gi] & (~lock_reg | (lock_idx_reg == IW'(gi)));
      assign win_onehot[gi] = (win_reg == IW'(gi));
    end
  endgenerate

  // Search starts at the round-robin pointer and wraps in ascending order.
  always_comb begin
    found = 1'b0;
    pick  = rr_reg;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_reg} + (IW+1)'(k);
      if (idx_w >= (IW+1)'(NREQ))
        idx_w = idx_w - (IW+1)'(NREQ);
      if (!found && eligible[idx_w[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx_w[IW-1:0];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    win_next      = win_reg;
    rr_next       = rr_reg;
    lock_idx_next = lock_idx_reg;
    lock_next     = lock_reg;
    last_next     = last_reg;
    data_next     = data_reg;
    cnt_next      = cnt_reg;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          win_next   = pick;
          data_next  = req_byte[pick];
          last_next  = i_last[pick];
          rr_next    = (pick == IW'(NREQ-1)) ? '0 : pick + IW'(1);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT_START;
      end
      WAIT_START: begin
        if (i_tx_busy) begin
          lock_next     = ~last_reg;
          lock_idx_next = win_reg;
          state_next    = WAIT_DONE;
        end else if (cnt_reg == 8'(START_TIMEOUT-1)) begin
          // uart_tx never acknowledged the start; drop any packet lock.
          err_next   = 1'b1;
          lock_next  = 1'b0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      win_reg      <= '0;
      rr_reg       <= '0;
      lock_idx_reg <= '0;
      lock_reg     <= 1'b0;
      last_reg     <= 1'b0;
      data_reg     <= 8'h00;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      win_reg      <= win_next;
      rr_reg       <= rr_next;
      lock_idx_reg <= lock_idx_next;
      lock_reg     <= lock_next;
      last_reg     <= last_next;
      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
    end
  end

  assign o_tx_act  = (state_reg == ISSUE);
  assign o_ack     = o_tx_act ? win_onehot : '0;
  assign o_grant   = (state_reg != IDLE) ? win_onehot : '0;
  assign o_busy    = (state_reg != IDLE);
  assign o_tx_data = data_reg;
  assign o_err     = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/bytes, a monitor checks
// every start pulse, grant hold, error pulse timing and busy release.
module tb_uart_tx_arbiter;

  logic        i_clock;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  i_last;
  logic [3:0]  o_ack;
  logic [3:0]  o_grant;
  logic [7:0]  o_tx_data;
  logic        o_tx_act;
  logic        i_tx_busy;
  logic        o_busy;
  logic        o_err;

  uart_tx_arbiter #(.NREQ(4), .START_TIMEOUT(15)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_data    (i_data),
    .i_last    (i_last),
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_tx_data (o_tx_data),
    .o_tx_act  (o_tx_act),
    .i_tx_busy (i_tx_busy),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct { int idx; logic [7:0] data; bit to; } exp_t;
  typedef struct { int delay; int len; } plan_t;

  exp_t  exp_q [$];
  plan_t plan_q [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_err_cyc = -100;
  logic [3:0] cur_grant = 4'b0000;

  logic [8:0] rq_mem [4][16];
  int rq_head [4];
  int rq_tail [4];

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enq(input int n, input logic [7:0] d, input logic l);
    rq_mem[n][rq_tail[n]] = {l, d};
    rq_tail[n]++;
  endtask

  task automatic expect_tx(input int n, input logic [7:0] d, input int delay, input int len);
    exp_t  e;
    plan_t p;
    e.idx = n; e.data = d; e.to = (delay == 0);
    p.delay = delay; p.len = len;
    exp_q.push_back(e);
    plan_q.push_back(p);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge i_clock);
      #2;
      done = (exp_q.size() == 0) && !o_busy &&
             (rq_head[0] == rq_tail[0]) && (rq_head[1] == rq_tail[1]) &&
             (rq_head[2] == rq_tail[2]) && (rq_head[3] == rq_tail[3]);
    end
    if (!done) chk(name, exp_q.size(), 0);
    repeat (3) @(negedge i_clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},     o_ack,     0);
    chk({tag, "_grant"},   o_grant,   0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_tx_act"},  o_tx_act,  0);
    chk({tag, "_busy"},    o_busy,    0);
    chk({tag, "_err"},     o_err,     0);
  endtask

  // Requesters: present the head of each byte queue, advance on ack.
  initial begin
    i_req = '0; i_data = '0; i_last = '0;
    for (int n = 0; n < 4; n++) begin rq_head[n] = 0; rq_tail[n] = 0; end
    forever begin
      @(negedge i_clock);
      for (int n = 0; n < 4; n++) begin
        if (o_ack[n] && rq_head[n] < rq_tail[n]) rq_head[n]++;
        if (rq_head[n] < rq_tail[n]) begin
          i_req[n]        = 1'b1;
          i_data[8*n +: 8] = rq_mem[n][rq_head[n]][7:0];
          i_last[n]       = rq_mem[n][rq_head[n]][8];
        end else begin
          i_req[n]        = 1'b0;
          i_data[8*n +: 8] = 8'h00;
          i_last[n]       = 1'b0;
        end
      end
    end
  end

  // uart_tx model: busy rises `delay` cycles after act for `len` cycles; delay 0 = never.
  initial begin
    int u_wait, u_len;
    plan_t p;
    i_tx_busy = 1'b0; u_wait = -1; u_len = 0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        i_tx_busy = 1'b0; u_wait = -1; u_len = 0;
      end else if (o_tx_act) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else begin p.delay = 2; p.len = 2; end
        u_wait = (p.delay == 0) ? -1 : p.delay;
        u_len  = p.len;
      end else if (u_wait > 0) begin
        u_wait--;
        if (u_wait == 0) begin i_tx_busy = 1'b1; u_wait = -1; end
      end else if (i_tx_busy) begin
        u_len--;
        if (u_len <= 0) i_tx_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    logic prev_busy_in;
    int   fall_cyc;
    prev_busy_in = 1'b0;
    fall_cyc = -100;
    forever begin
      @(negedge i_clock);
      #1;
      if (o_tx_act) begin
        if (exp_q.size() == 0) chk("act_unexpected", o_tx_act, 0);
        else begin
          e = exp_q.pop_front();
          chk("tx_data", o_tx_data, e.data);
          chk("ack_with_act", o_ack, 32'(1) << e.idx);
          cur_grant = 4'(32'(1) << e.idx);
          if (e.to) exp_err_cyc = cyc + 16;
        end
      end else begin
        chk("ack_outside_issue", o_ack, 0);
      end
      if (o_busy) chk("grant_held", o_grant, cur_grant);
      else        chk("grant_idle", o_grant, 0);
      chk("err_pulse", o_err, (cyc == exp_err_cyc));
      if (cyc == exp_err_cyc) chk("idle_after_timeout", o_busy, 0);
      if (cyc == fall_cyc + 1) chk("busy_release", o_busy, 0);
      if (prev_busy_in && !i_tx_busy) fall_cyc = cyc;
      prev_busy_in = i_tx_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    #1 chk_reset_outputs("reset");
    #1 i_reset = 1'b0;

    // Round robin from pointer 0: grant order 0,1,2,3,0.
    @(negedge i_clock); #2;
    enq(0, 8'h10, 1); enq(0, 8'h14, 1); enq(1, 8'h11, 1);
    enq(2, 8'h12, 1); enq(3, 8'h13, 1);
    expect_tx(0, 8'h10, 2, 3);
    expect_tx(1, 8'h11, 5, 1);
    expect_tx(2, 8'h12, 10, 2);
    expect_tx(3, 8'h13, 1, 4);
    expect_tx(0, 8'h14, 4, 4);
    wait_drain("rr_drain");

    // Single requester, with one-cycle request-to-issue latency.
    @(negedge i_clock); #2;
    enq(1, 8'h41, 1);
    expect_tx(1, 8'h41, 10, 3);
    @(negedge i_clock); #2;
    chk("req_seen", i_req[1], 1);
    @(negedge i_clock); #2;
    chk("latency_act", o_tx_act, 1);
    chk("latency_ack", o_ack, 4'b0010);
    wait_drain("single_drain");

    // Packet lock: "Hi" from requester 2 back-to-back, then requester 0.
    @(negedge i_clock); #2;
    enq(2, 8'h48, 0); enq(2, 8'h69, 1); enq(0, 8'h50, 1);
    expect_tx(2, 8'h48, 3, 2);
    expect_tx(2, 8'h69, 2, 2);
    expect_tx(0, 8'h50, 2, 2);
    wait_drain("lock_drain");

    // Timeout inside a locked packet clears the lock, so requester 3 gets in.
    @(negedge i_clock); #2;
    enq(1, 8'hA5, 0); enq(1, 8'hB6, 0); enq(1, 8'hC7, 1); enq(3, 8'hD8, 1);
    expect_tx(1, 8'hA5, 2, 2);
    expect_tx(1, 8'hB6, 0, 0);
    expect_tx(3, 8'hD8, 2, 2);
    expect_tx(1, 8'hC7, 2, 2);
    wait_drain("timeout_drain");

    // Reset during WAIT_DONE; afterwards requester 0 must win over 2.
    @(negedge i_clock); #2;
    enq(1, 8'h58, 1);
    expect_tx(1, 8'h58, 2, 12);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge i_clock); #2;
      seen = i_tx_busy && o_busy;
    end
    chk("reached_wait_done", seen, 1);
    enq(0, 8'h59, 1); enq(2, 8'h5A, 1);
    expect_tx(0, 8'h59, 2, 2);
    expect_tx(2, 8'h5A, 2, 2);
    #1 i_reset = 1'b1;
    #1 chk_reset_outputs("midreset");
    repeat (2) @(negedge i_clock);
    #2 i_reset = 1'b0;
    wait_drain("reset_drain");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter START_TIMEOUT, default 15, maximum cycles to wait for i_tx_busy to rise after a start pulse; legal range 1..255.
REQ-003 i_clock  input  1  single clock; all logic on its rising edge.
REQ-004 i_reset  input  1  reset; asynchronous, active-high.
REQ-005 i_req  input  NREQ  per-requester "byte pending" level.
REQ-006 i_data  input  8*NREQ  requester n byte on bits [8n+7:8n].
REQ-007 i_last  input  NREQ  per-requester flag: this byte ends a packet.
REQ-008 o_ack  output  NREQ  one-cycle pulse: requester's byte consumed.
REQ-009 o_grant  output  NREQ  one-hot grant, held for the whole transfer.
REQ-010 o_tx_data  output  8  byte to uart_tx data input.
REQ-011 o_tx_act  output  1  one-cycle start pulse to uart_tx act input.
REQ-012 i_tx_busy  input  1  uart_tx busy output.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.
REQ-014 o_err  output  1  one-cycle pulse on start timeout.

Function
REQ-015 State machine states SHALL be IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-016 In IDLE with any eligible i_req high, the block SHALL select a winner, register the winner's index, i_data byte and i_last bit, and move to ISSUE on the next edge.
REQ-017 Arbitration SHALL be round-robin: the search starts at index (last granted + 1) mod NREQ and proceeds in ascending index order with wrap-around; after reset the search starts at index 0.
REQ-018 When lock is set, only the locked requester SHALL be eligible; other requests are ignored however long they wait.
REQ-019 In ISSUE the block SHALL, for exactly one cycle, drive o_tx_act=1, the latched byte on o_tx_data and o_ack[winner]=1, then move to WAIT_START.
REQ-020 Each requester SHALL update i_data/i_last or drop i_req by the cycle after its o_ack; the block SHALL NOT sample that requester again before WAIT_DONE completes.
REQ-021 In WAIT_START, i_tx_busy=1 SHALL move the state to WAIT_DONE; otherwise a counter increments each cycle.
REQ-022 If START_TIMEOUT cycles elapse in WAIT_START without i_tx_busy, o_err SHALL pulse one cycle, lock SHALL clear, and the state SHALL return to IDLE.
REQ-023 In WAIT_DONE, i_tx_busy=0 SHALL return the state to IDLE; the next transfer's ISSUE SHALL therefore occur no earlier than 2 cycles after busy falls.
REQ-024 When a transfer reaches WAIT_DONE, lock SHALL be set to the winner if its latched i_last=0 and cleared if i_last=1.
REQ-025 o_grant SHALL be one-hot for the winner from ISSUE through the end of WAIT_DONE or the timeout, and all-zero in IDLE.
REQ-026 o_tx_data SHALL hold the latched byte from ISSUE until the next ISSUE.
REQ-027 Outside ISSUE, o_tx_act and o_ack SHALL be 0.
REQ-028 A change in i_req during a transfer SHALL have no effect until the state is IDLE again.
REQ-029 Minimum transfer latency SHALL be: request seen in IDLE, then ISSUE 1 cycle later.

Reset
REQ-030 Asserting i_reset at any time, including mid-transfer, SHALL immediately force: state IDLE, lock cleared, round-robin pointer to 0, counter 0, o_ack=0, o_grant=0, o_tx_data=8'h00, o_tx_act=0, o_busy=0, o_err=0.
REQ-031 After reset deasserts, the first arbitration SHALL use the normal IDLE rules; any byte in flight in uart_tx is abandoned without ack replay.

Verification
REQ-032 Single requester: i_req=4'b0010, data 8'h41, last=1, busy high 2..10 cycles after act -> one act pulse with o_tx_data=8'h41, o_ack=4'b0010 on the same cycle, o_grant=4'b0010 until busy falls.
REQ-033 Round-robin: all four requesters held high with last=1 -> grant order 0,1,2,3,0 and each o_ack coincides with its act.
REQ-034 Packet lock: requester 2 sends "Hi" (last=0 on 'H', last=1 on 'i') while requester 0 requests -> 'H','i' sent back-to-back on grant 2, then requester 0 is granted.
REQ-035 Timeout: act issued, i_tx_busy held 0 -> o_err pulses exactly 15 cycles after entering WAIT_START, state IDLE, lock cleared.
REQ-036 Reset mid-transfer: assert i_reset during WAIT_DONE -> all outputs at reset values within the same cycle; after release, requester 0 wins first.
